instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Upstream neighbour of the instruction decoder. Pulls 32-bit SoftMC instructions from the host instruction FIFO and classifies each one.
- DDR command instructions go to the decoder as a registered one-cycle `dec_en` strobe plus `dec_instr`.
- WAIT instructions are executed locally as idle cycles (`dec_en` low). BUSDIR and END instructions are consumed without reaching the decoder.

Parameters:
- INSTR_WIDTH, 32, instruction word width.
- WAIT_WIDTH, 28, width of the WAIT cycle-count field, taken from `instr[WAIT_WIDTH-1:0]`.

Ports:
- clk  input  1  sole clock, DFI/controller domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins execution of the FIFO contents. Ignored unless in IDLE.
- in_valid  input  1  FIFO has an instruction.
- in_instr  input  INSTR_WIDTH  FIFO head word.
- in_ready  output  1  pop; the word transfers when `in_valid && in_ready`.
- dec_en  output  1  decoder enable, registered.
- dec_instr  output  INSTR_WIDTH  instruction to the decoder, registered. Valid only when `dec_en`=1.
- busdir  output  1  data bus direction: 0 = read, 1 = write.
- busy  output  1  high in RUN and WAIT.
- done  output  1  one-cycle pulse on END.
- err_unknown  output  1  sticky flag for an unknown instruction type. Cleared by `rst` or `start`.

Behaviour:
- Type field is `instr[31:28]`:
  - DDR: bit31 = 1. Bits 30:28 are don't-care here; the decoder interprets the rest.
  - WAIT = 4'b0001.
  - BUSDIR = 4'b0010, direction in `instr[0]`.
  - END = 4'b0100.
  - Any other value is unknown.
- Reset values: `in_ready`=0, `dec_en`=0, `dec_instr`=0, `busdir`=0, `busy`=0, `done`=0, `err_unknown`=0, state=IDLE, wait counter=0.
- States and transitions:
  - IDLE: `in_ready`=0. On `start`: clear `err_unknown`, go to RUN.
  - RUN: `in_ready`=1 (combinational from state, so one pop per cycle). Actions on an accepted word:
    - DDR: next cycle `dec_en`=1 and `dec_instr`=word. Back-to-back DDR words give back-to-back `dec_en`.
    - WAIT with N=0: no-op, stay in RUN.
    - WAIT with N≥1: load counter with N, go to WAIT.
    - BUSDIR: `busdir` <= `instr[0]` next cycle.
    - END: `done`=1 next cycle, go to IDLE.
    - Unknown: `err_unknown`<=1, word dropped, stay in RUN.
  - RUN with no accepted word: `dec_en`=0 next cycle (bubble).
  - WAIT: `in_ready`=0, `dec_en`=0. Counter decrements by 1 each cycle; return to RUN on the cycle the counter reaches 1.
- WAIT timing: exactly N cycles with `in_ready`=0 follow the accept cycle. The next pop occurs N+1 cycles after the WAIT pop.
- Latency: a DDR word accepted at cycle t shows `dec_en` at t+1.
- `dec_en` is 0 in every cycle after a non-DDR accept.
- `start` asserted while in RUN or WAIT is ignored, including `err_unknown` clear.
- `start` and `in_valid` in the same cycle in IDLE: no pop; popping begins the next cycle.
- `rst` mid-WAIT or mid-RUN: all outputs and the counter return to their reset values immediately (asynchronous). Any word presented in that cycle is not popped.
- Counter: WAIT_WIDTH bits, loaded unsigned, never wraps. N = 2^WAIT_WIDTH−1 must work.

Decomposition:
- Add to `softMC.inc`:
  - `INSTR_TYPE_OFFSET 31:28`, `WAIT_CNT_OFFSET`.
  - Type codes `INSTR_TYPE_WAIT`, `INSTR_TYPE_BUSDIR`, `INSTR_TYPE_END`.
  - `INSTR_DDR_BIT 31`.
  - State encodings `SEQ_IDLE/RUN/WAIT`.
- Sub-module `seq_wait_counter`: load / decrement / last-cycle flag, WAIT_WIDTH wide.

Test Plan:
- Reset, then `start`; FIFO = {DDR 0x8000_1234, DDR 0x8000_5678, END} → `dec_en`=1 for two consecutive cycles with `dec_instr` 0x80001234 then 0x80005678; `done` pulse on the next cycle; `busy`=0 afterwards.
- FIFO = {DDR A, WAIT 5, DDR B, END} → exactly 5 `in_ready`=0 cycles after the WAIT pop; `dec_en` edges for A and B are 7 cycles apart.
- FIFO = {WAIT 0, BUSDIR 1, DDR, BUSDIR 0, END} → no stall; `busdir` rises the cycle after the first BUSDIR pop and falls the cycle after the second; `err_unknown`=0.
- FIFO = {0x3000_0000, DDR, END} → `err_unknown`=1 and remains set after END; the DDR is still issued; the next `start` clears `err_unknown`.
- `rst` pulse 3 cycles into a WAIT 100 → `in_ready`/`busy`/`dec_en` immediately 0, state IDLE; after release, `start` resumes popping from the current FIFO head.
- `in_valid` deasserted for 2 cycles between two DDR words → exactly 2 cycles with `dec_en`=0 between them; a `start` pulse during RUN has no effect.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared field positions, type codes, state encodings and the instruction
// classifier for the SoftMC instruction sequencer.
package instr_sequencer_pkg;

  localparam int INSTR_TYPE_HI = 31;
  localparam int INSTR_TYPE_LO = 28;
  localparam int INSTR_DDR_BIT = 31;
  localparam int WAIT_CNT_LO   = 0;

  localparam logic [3:0] INSTR_TYPE_WAIT   = 4'b0001;
  localparam logic [3:0] INSTR_TYPE_BUSDIR = 4'b0010;
  localparam logic [3:0] INSTR_TYPE_END    = 4'b0100;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_RUN  = 2'b01,
    SEQ_WAIT = 2'b10
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_DDR     = 3'd0,
    CLS_WAIT    = 3'd1,
    CLS_BUSDIR  = 3'd2,
    CLS_END     = 3'd3,
    CLS_UNKNOWN = 3'd4
  } instr_class_e;

  // The DDR bit takes priority over the type nibble; bits 30:28 are the decoder's business.
  function automatic instr_class_e classify_instr(input logic [31:0] instr);
    instr_class_e cls;
    if (instr[INSTR_DDR_BIT]) begin
      cls = CLS_DDR;
    end else begin
      case (instr[INSTR_TYPE_HI:INSTR_TYPE_LO])
        INSTR_TYPE_WAIT:   cls = CLS_WAIT;
        INSTR_TYPE_BUSDIR: cls = CLS_BUSDIR;
        INSTR_TYPE_END:    cls = CLS_END;
        default:           cls = CLS_UNKNOWN;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Host FIFO, decoder and status signals of the instruction sequencer.
// master = host/FIFO side, slave = sequencer.
interface instr_sequencer_if #(
  parameter int INSTR_WIDTH = 32
);
  logic                   start;
  logic                   in_valid;
  logic [INSTR_WIDTH-1:0] in_instr;
  logic                   in_ready;
  logic                   dec_en;
  logic [INSTR_WIDTH-1:0] dec_instr;
  logic                   busdir;
  logic                   busy;
  logic                   done;
  logic                   err_unknown;

  modport master (
    output start, in_valid, in_instr,
    input  in_ready, dec_en, dec_instr, busdir, busy, done, err_unknown
  );

  modport slave (
    input  start, in_valid, in_instr,
    output in_ready, dec_en, dec_instr, busdir, busy, done, err_unknown
  );
endinterface

// File: rtl/seq_wait_counter.sv
// WAIT cycle counter: parallel load, decrement that saturates at zero,
// and a flag marking the final WAIT cycle.
module seq_wait_counter #(
  parameter int WAIT_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WAIT_WIDTH-1:0] load_val,
  input  logic                  dec,
  output logic                  last
);

  logic [WAIT_WIDTH-1:0] cnt_q;
  logic [WAIT_WIDTH-1:0] cnt_d;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == WAIT_WIDTH'(1));

endmodule

// File: rtl/instr_sequencer.sv
// Pops SoftMC instructions from the host FIFO, forwards DDR commands to the
// decoder and executes WAIT / BUSDIR / END locally.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int WAIT_WIDTH  = 28
) (
  input logic               clk,
  input logic               rst,
  instr_sequencer_if.slave  bus
);

  seq_state_e             state_q, state_d;
  logic                   dec_en_q, dec_en_d;
  logic [INSTR_WIDTH-1:0] dec_instr_q, dec_instr_d;
  logic                   busdir_q, busdir_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   in_ready_s;
  logic                   accept_s;
  instr_class_e           cls_s;
  logic [WAIT_WIDTH-1:0]  wait_n_s;
  logic                   cnt_load_s;
  logic                   cnt_dec_s;
  logic                   cnt_last_s;

  // Popping depends only on the state so reset drops in_ready immediately.
  assign in_ready_s = (state_q == SEQ_RUN);
  assign accept_s   = in_ready_s && bus.in_valid;
  assign cls_s      = classify_instr(bus.in_instr);
  assign wait_n_s   = bus.in_instr[WAIT_CNT_LO +: WAIT_WIDTH];

  seq_wait_counter #(
    .WAIT_WIDTH (WAIT_WIDTH)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (wait_n_s),
    .dec      (cnt_dec_s),
    .last     (cnt_last_s)
  );

  // Next-state and next-output logic; strobes default low, status holds.
  always_comb begin
    state_d     = state_q;
    dec_en_d    = 1'b0;
    dec_instr_d = dec_instr_q;
    busdir_d    = busdir_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (bus.start) begin
          err_d   = 1'b0;
          state_d = SEQ_RUN;
        end else begin
          state_d = SEQ_IDLE;
        end
      end

      SEQ_RUN: begin
        if (accept_s) begin
          case (cls_s)
            CLS_DDR: begin
              dec_en_d    = 1'b1;
              dec_instr_d = bus.in_instr;
            end
            CLS_WAIT: begin
              // A zero count is a plain no-op: no stall at all.
              if (wait_n_s != '0) begin
                cnt_load_s = 1'b1;
                state_d    = SEQ_WAIT;
              end else begin
                state_d    = SEQ_RUN;
              end
            end
            CLS_BUSDIR: busdir_d = bus.in_instr[0];
            CLS_END: begin
              done_d  = 1'b1;
              state_d = SEQ_IDLE;
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = SEQ_RUN;
        end
      end

      SEQ_WAIT: begin
        cnt_dec_s = 1'b1;
        if (cnt_last_s) begin
          state_d = SEQ_RUN;
        end else begin
          state_d = SEQ_WAIT;
        end
      end

      default: state_d = SEQ_IDLE;
    endcase

    busy_d = (state_d != SEQ_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      dec_en_q    <= 1'b0;
      dec_instr_q <= '0;
      busdir_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_en_q    <= dec_en_d;
      dec_instr_q <= dec_instr_d;
      busdir_q    <= busdir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.dec_en      = dec_en_q;
  assign bus.dec_instr   = dec_instr_q;
  assign bus.busdir      = busdir_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_unknown = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: directed programs plus random programs and FIFO
// gaps, compared against a cycle-arithmetic model of the sequencer.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  instr_sequencer_if #(.INSTR_WIDTH(32)) bus ();

  instr_sequencer #(.INSTR_WIDTH(32), .WAIT_WIDTH(28)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: program queue, "running" flag, earliest cycle index of the next pop.
  logic [31:0] prog[$];
  bit          m_run    = 1'b0;
  bit          m_err    = 1'b0;
  bit          m_busdir = 1'b0;
  int          m_next   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic step(input bit st, input bit allow_valid);
    bit          exp_rdy;
    bit          pop;
    bit          e_dec_en;
    bit          e_done;
    logic [31:0] e_instr;
    logic [31:0] w;
    logic [3:0]  t;
    e_dec_en = 1'b0;
    e_done   = 1'b0;
    e_instr  = 32'h0;
    bus.start    = st;
    bus.in_valid = allow_valid && (prog.size() > 0);
    bus.in_instr = bus.in_valid ? prog[0] : 32'h0;
    exp_rdy = m_run && (cyc >= m_next);
    chk("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_rdy});
    pop = exp_rdy && bus.in_valid;
    if (!m_run && st) begin
      m_run  = 1'b1;
      m_err  = 1'b0;
      m_next = cyc + 1;
    end else if (pop) begin
      w = prog.pop_front();
      t = w[31:28];
      m_next = cyc + 1;
      if (w[31]) begin
        e_dec_en = 1'b1;
        e_instr  = w;
      end else if (t == 4'h1) begin
        m_next = cyc + 1 + int'(w[27:0]);
      end else if (t == 4'h2) begin
        m_busdir = w[0];
      end else if (t == 4'h4) begin
        e_done = 1'b1;
        m_run  = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("dec_en", {31'h0, bus.dec_en}, {31'h0, e_dec_en});
    if (e_dec_en) chk("dec_instr", bus.dec_instr, e_instr);
    chk("done", {31'h0, bus.done}, {31'h0, e_done});
    chk("busy", {31'h0, bus.busy}, {31'h0, m_run});
    chk("busdir", {31'h0, bus.busdir}, {31'h0, m_busdir});
    chk("err_unknown", {31'h0, bus.err_unknown}, {31'h0, m_err});
  endtask

  // Start the queued program and run it to END; mode 1 randomises in_valid and stray starts.
  task automatic run_prog(input bit rnd);
    bit v;
    bit st;
    step(1'b1, 1'b1);
    for (int i = 0; i < 1500 && m_run; i++) begin
      v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      st = rnd && (prog.size() > 1) && ($urandom_range(0, 7) == 0);
      step(st, v);
    end
    chk("end_idle", {31'h0, bus.busy}, 32'h0);
  endtask

  // Asynchronous reset in the middle of a cycle, held over one edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_dec_en", {31'h0, bus.dec_en}, 32'h0);
    chk("rst_busdir", {31'h0, bus.busdir}, 32'h0);
    m_run    = 1'b0;
    m_err    = 1'b0;
    m_busdir = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = (prog.size() > 0);
    bus.in_instr = bus.in_valid ? prog[0] : 32'h0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    chk("rst_hold_rdy", {31'h0, bus.in_ready}, 32'h0);
  endtask

  task automatic gen_random_prog();
    int          n;
    int          r;
    logic [31:0] rw;
    logic [3:0]  unk[5];
    unk = '{4'h0, 4'h3, 4'h5, 4'h6, 4'h7};
    n = $urandom_range(2, 6);
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 9);
      rw = $urandom();
      if (r < 4)       prog.push_back({1'b1, rw[30:0]});
      else if (r < 6)  prog.push_back({4'h1, 28'($urandom_range(1, 6))});
      else if (r < 8)  prog.push_back({4'h2, 27'h0, rw[0]});
      else if (r == 8) prog.push_back({unk[$urandom_range(0, 4)], rw[27:0]});
      else             prog.push_back(32'h1000_0000);
    end
    prog.push_back(32'h4000_0000);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("reset_dec_en", {31'h0, bus.dec_en}, 32'h0);
    chk("reset_dec_instr", bus.dec_instr, 32'h0);
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("reset_done", {31'h0, bus.done}, 32'h0);
    chk("reset_err", {31'h0, bus.err_unknown}, 32'h0);

    // Back-to-back DDR then END; idle with a valid head must not pop.
    prog = '{32'h8000_1234, 32'h8000_5678, 32'h4000_0000};
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run_prog(1'b0);

    // WAIT 5 between two DDR words.
    prog = '{32'h8000_00AA, 32'h1000_0005, 32'h8000_00BB, 32'h4000_0000};
    run_prog(1'b0);

    // WAIT 0 and bus-direction toggling.
    prog = '{32'h1000_0000, 32'h2000_0001, 32'h8000_0C0D, 32'h2000_0000, 32'h4000_0000};
    run_prog(1'b0);

    // Unknown type sets the sticky error; the next start clears it.
    prog = '{32'h3000_0000, 32'h8000_0EEE, 32'h4000_0000};
    run_prog(1'b0);
    step(1'b0, 1'b0);
    prog = '{32'h4000_0000};
    run_prog(1'b0);

    // Reset three cycles into WAIT 100, then resume from the FIFO head.
    prog = '{32'h8000_0111, 32'h1000_0064, 32'h8000_0222, 32'h4000_0000};
    step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    mid_reset();
    run_prog(1'b0);

    // Maximum WAIT count: still stalled after many cycles.
    prog = '{32'h1FFF_FFFF, 32'h4000_0000};
    step(1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b1);
    mid_reset();
    run_prog(1'b0);

    // Two-cycle FIFO gap between DDR words, with a stray start during RUN.
    prog = '{32'h8000_0A0A, 32'h8000_0B0B, 32'h4000_0000};
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      prog.delete();
      gen_random_prog();
      run_prog(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
